// File: rtl/mc_scoreboard_if.sv
// Bus between the decode stage and the multi-cycle writer scoreboard.
// The decode side drives requests, sources and writeback returns; the
// scoreboard side answers with stall/ack and its registered state.
interface mc_scoreboard_if #(
   parameter int unsigned NREG  = 32,
   parameter int unsigned CNT_W = 3
);
   logic              issue_req;
   logic [4:0]        issue_rd;
   logic [4:0]        rs1D;
   logic [4:0]        rs2D;
   logic [4:0]        rdD;
   logic              rdD_we;
   logic              wb_valid;
   logic [4:0]        wb_rd;
   logic              flush;
   logic              stall;
   logic              issue_ack;
   logic [NREG-1:0]   pending;
   logic [CNT_W-1:0]  out_cnt;
   logic              wb_err;

   modport master (
      output issue_req, issue_rd, rs1D, rs2D, rdD, rdD_we, wb_valid, wb_rd, flush,
      input  stall, issue_ack, pending, out_cnt, wb_err
   );

   modport slave (
      input  issue_req, issue_rd, rs1D, rs2D, rdD, rdD_we, wb_valid, wb_rd, flush,
      output stall, issue_ack, pending, out_cnt, wb_err
   );
endinterface

// File: rtl/mc_scoreboard.sv
// Producer-side register scoreboard: tracks destinations of in-flight
// multi-cycle writers (divider, load miss) and stalls decode on RAW/WAW
// hazards against them. A same-cycle writeback releases consumers.
module mc_scoreboard #(
   parameter int unsigned NREG    = 32,
   parameter int unsigned MAX_OUT = 4,
   parameter int unsigned CNT_W   = 3
) (
   input  logic           clk,
   input  logic           resetn,
   mc_scoreboard_if.slave sb
);

   logic [NREG-1:0]  pending_q, pending_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic [NREG-1:0]  wb_sel;
   logic [NREG-1:0]  effp;
   logic             wb_hit;
   logic             raw;
   logic             waw;
   logic             full;
   logic             stall_c;
   logic             ack_c;
   logic             set_ok;

   // Hazard detection against effective pending (writeback releases same cycle)
   always_comb begin
      wb_sel = '0;
      if (sb.wb_valid) wb_sel[sb.wb_rd] = 1'b1;
      effp    = pending_q & ~wb_sel;
      wb_hit  = sb.wb_valid & pending_q[sb.wb_rd];
      raw     = ((sb.rs1D != 5'd0) & effp[sb.rs1D]) |
                ((sb.rs2D != 5'd0) & effp[sb.rs2D]);
      waw     = sb.rdD_we & (sb.rdD != 5'd0) & effp[sb.rdD];
      full    = (cnt_q == CNT_W'(MAX_OUT)) & ~wb_hit;
      stall_c = ~sb.flush & (raw | waw | (sb.issue_req & full));
      ack_c   = sb.issue_req & ~stall_c & ~sb.flush;
      set_ok  = ack_c & (sb.issue_rd != 5'd0);
   end

   // Next-state: flush wins, otherwise clear-then-set plus sticky error
   always_comb begin
      pending_d = pending_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      if (sb.flush) begin
         pending_d = '0;
         cnt_d     = '0;
      end else begin
         if (wb_hit) pending_d[sb.wb_rd] = 1'b0;
         if (set_ok) pending_d[sb.issue_rd] = 1'b1;
         // Count only bits that actually become set, so an issue to a register
         // that stays pending (or is cleared and re-set) keeps count == popcount.
         cnt_d = cnt_q - CNT_W'(wb_hit) + CNT_W'(set_ok & ~effp[sb.issue_rd]);
         if (sb.wb_valid & ~wb_hit) err_d = 1'b1;
      end
   end

   // State registers, asynchronously cleared
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pending_q <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

   assign sb.stall     = stall_c;
   assign sb.issue_ack = ack_c;
   assign sb.pending   = pending_q;
   assign sb.out_cnt   = cnt_q;
   assign sb.wb_err    = err_q;

endmodule

// File: tb/tb_mc_scoreboard.sv
// Directed bench for mc_scoreboard: inputs change on the falling edge,
// combinational outputs are sampled before the rising edge, registered
// outputs 1 time unit after it.
module tb_mc_scoreboard;

   logic clk;
   logic resetn;
   int unsigned vectors;
   int unsigned miscompares;

   mc_scoreboard_if #(.NREG(32), .CNT_W(3)) bus ();

   mc_scoreboard #(.NREG(32), .MAX_OUT(4), .CNT_W(3)) dut (
      .clk    (clk),
      .resetn (resetn),
      .sb     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      bus.issue_req = 1'b0;
      bus.issue_rd  = 5'd0;
      bus.rs1D      = 5'd0;
      bus.rs2D      = 5'd0;
      bus.rdD       = 5'd0;
      bus.rdD_we    = 1'b0;
      bus.wb_valid  = 1'b0;
      bus.wb_rd     = 5'd0;
      bus.flush     = 1'b0;
   endtask

   task automatic to_drive();
      @(negedge clk);
   endtask

   task automatic past_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      resetn = 1'b0;
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd5;
      repeat (2) past_edge();
      vectors++;
      if (bus.pending !== 32'h0) begin miscompares++; $display("FAIL reset_pending: got %h expected %h", bus.pending, 32'h0); end
      vectors++;
      if (bus.out_cnt !== 3'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d expected 0", bus.out_cnt); end
      vectors++;
      if (bus.wb_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", bus.wb_err); end
      vectors++;
      if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
      to_drive();
      idle_inputs();
      resetn = 1'b1;
      to_drive();
      bus.issue_req = 1'b1;
      bus.issue_rd  = 5'd7;
      #1;
      vectors++;
      if (bus.issue_ack !== 1'b1) begin miscompares++; $display("FAIL reset_first_ack: got %b expected 1", bus.issue_ack); end
      past_edge();
      vectors++;
      if (bus.pending !== 32'h80) begin miscompares++; $display("FAIL reset_first_pending: got %h expected %h", bus.pending, 32'h80); end
      vectors++;
      if (bus.out_cnt !== 3'd1) begin miscompares++; $display("FAIL reset_first_cnt: got %0d expected 1", bus.out_cnt); end
   endtask

   // r7 pending from test_reset
   task automatic test_raw_release();
      to_drive();
      idle_inputs();
      bus.rs1D = 5'd7;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++;
         if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL raw_stall[%0d]: got %b expected 1", i, bus.stall); end
         to_drive();
      end
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd7;
      #1;
      vectors++;
      if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL raw_release_stall: got %b expected 0", bus.stall); end
      past_edge();
      vectors++;
      if (bus.pending !== 32'h0) begin miscompares++; $display("FAIL raw_release_pending: got %h expected 0", bus.pending); end
      vectors++;
      if (bus.out_cnt !== 3'd0) begin miscompares++; $display("FAIL raw_release_cnt: got %0d expected 0", bus.out_cnt); end
      vectors++;
      if (bus.wb_err !== 1'b0) begin miscompares++; $display("FAIL raw_release_err: got %b expected 0", bus.wb_err); end
   endtask

   task automatic test_waw();
      to_drive();
      idle_inputs();
      bus.issue_req = 1'b1;
      bus.issue_rd  = 5'd9;
      past_edge();
      to_drive();
      idle_inputs();
      bus.rdD_we = 1'b1;
      bus.rdD    = 5'd9;
      #1;
      vectors++;
      if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL waw_stall: got %b expected 1", bus.stall); end
      to_drive();
      bus.rdD       = 5'd0;
      bus.issue_req = 1'b1;
      bus.issue_rd  = 5'd0;
      #1;
      vectors++;
      if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL waw_r0_stall: got %b expected 0", bus.stall); end
      vectors++;
      if (bus.issue_ack !== 1'b1) begin miscompares++; $display("FAIL waw_r0_ack: got %b expected 1", bus.issue_ack); end
      past_edge();
      vectors++;
      if (bus.pending !== 32'h200) begin miscompares++; $display("FAIL waw_r0_pending: got %h expected %h", bus.pending, 32'h200); end
      vectors++;
      if (bus.out_cnt !== 3'd1) begin miscompares++; $display("FAIL waw_r0_cnt: got %0d expected 1", bus.out_cnt); end
      to_drive();
      idle_inputs();
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd9;
      past_edge();
      vectors++;
      if (bus.out_cnt !== 3'd0) begin miscompares++; $display("FAIL waw_drain_cnt: got %0d expected 0", bus.out_cnt); end
   endtask

   task automatic test_full();
      for (int r = 1; r <= 4; r++) begin
         to_drive();
         idle_inputs();
         bus.issue_req = 1'b1;
         bus.issue_rd  = 5'(r);
         #1;
         vectors++;
         if (bus.issue_ack !== 1'b1) begin miscompares++; $display("FAIL full_fill_ack[r%0d]: got %b expected 1", r, bus.issue_ack); end
         past_edge();
      end
      vectors++;
      if (bus.out_cnt !== 3'd4) begin miscompares++; $display("FAIL full_cnt: got %0d expected 4", bus.out_cnt); end
      vectors++;
      if (bus.pending !== 32'h1E) begin miscompares++; $display("FAIL full_pending: got %h expected %h", bus.pending, 32'h1E); end
      to_drive();
      bus.issue_rd = 5'd5;
      #1;
      vectors++;
      if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL full_stall: got %b expected 1", bus.stall); end
      vectors++;
      if (bus.issue_ack !== 1'b0) begin miscompares++; $display("FAIL full_nack: got %b expected 0", bus.issue_ack); end
      to_drive();
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd2;
      #1;
      vectors++;
      if (bus.issue_ack !== 1'b1) begin miscompares++; $display("FAIL full_wb_ack: got %b expected 1", bus.issue_ack); end
      past_edge();
      vectors++;
      if (bus.pending !== 32'h3A) begin miscompares++; $display("FAIL full_wb_pending: got %h expected %h", bus.pending, 32'h3A); end
      vectors++;
      if (bus.out_cnt !== 3'd4) begin miscompares++; $display("FAIL full_wb_cnt: got %0d expected 4", bus.out_cnt); end
      for (int r = 1; r <= 5; r++) begin
         if (r != 2) begin
            to_drive();
            idle_inputs();
            bus.wb_valid = 1'b1;
            bus.wb_rd    = 5'(r);
            past_edge();
         end
      end
      vectors++;
      if (bus.out_cnt !== 3'd0) begin miscompares++; $display("FAIL full_drain_cnt: got %0d expected 0", bus.out_cnt); end
      vectors++;
      if (bus.wb_err !== 1'b0) begin miscompares++; $display("FAIL full_drain_err: got %b expected 0", bus.wb_err); end
   endtask

   task automatic test_simul_clear_set();
      to_drive();
      idle_inputs();
      bus.issue_req = 1'b1;
      bus.issue_rd  = 5'd6;
      past_edge();
      to_drive();
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd6;
      #1;
      vectors++;
      if (bus.issue_ack !== 1'b1) begin miscompares++; $display("FAIL simul_ack: got %b expected 1", bus.issue_ack); end
      past_edge();
      vectors++;
      if (bus.pending !== 32'h40) begin miscompares++; $display("FAIL simul_pending: got %h expected %h", bus.pending, 32'h40); end
      vectors++;
      if (bus.out_cnt !== 3'd1) begin miscompares++; $display("FAIL simul_cnt: got %0d expected 1", bus.out_cnt); end
      to_drive();
      idle_inputs();
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd6;
      past_edge();
   endtask

   task automatic test_back_to_back();
      to_drive();
      idle_inputs();
      bus.issue_req = 1'b1;
      bus.issue_rd  = 5'd7;
      bus.rs2D      = 5'd7;
      #1;
      vectors++;
      if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL b2b_issue_stall: got %b expected 0", bus.stall); end
      to_drive();
      bus.issue_req = 1'b0;
      #1;
      vectors++;
      if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL b2b_consumer_stall: got %b expected 1", bus.stall); end
      to_drive();
      idle_inputs();
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd7;
      past_edge();
      vectors++;
      if (bus.out_cnt !== 3'd0) begin miscompares++; $display("FAIL b2b_drain_cnt: got %0d expected 0", bus.out_cnt); end
   endtask

   task automatic test_flush_err();
      for (int r = 3; r <= 4; r++) begin
         to_drive();
         idle_inputs();
         bus.issue_req = 1'b1;
         bus.issue_rd  = 5'(r);
         past_edge();
      end
      to_drive();
      idle_inputs();
      bus.flush     = 1'b1;
      bus.issue_req = 1'b1;
      bus.issue_rd  = 5'd8;
      bus.rs1D      = 5'd3;
      #1;
      vectors++;
      if (bus.issue_ack !== 1'b0) begin miscompares++; $display("FAIL flush_ack: got %b expected 0", bus.issue_ack); end
      vectors++;
      if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL flush_stall: got %b expected 0", bus.stall); end
      past_edge();
      vectors++;
      if (bus.pending !== 32'h0) begin miscompares++; $display("FAIL flush_pending: got %h expected 0", bus.pending); end
      vectors++;
      if (bus.out_cnt !== 3'd0) begin miscompares++; $display("FAIL flush_cnt: got %0d expected 0", bus.out_cnt); end
      vectors++;
      if (bus.wb_err !== 1'b0) begin miscompares++; $display("FAIL flush_err: got %b expected 0", bus.wb_err); end
      to_drive();
      idle_inputs();
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd3;
      past_edge();
      vectors++;
      if (bus.wb_err !== 1'b1) begin miscompares++; $display("FAIL err_set: got %b expected 1", bus.wb_err); end
      vectors++;
      if (bus.out_cnt !== 3'd0) begin miscompares++; $display("FAIL err_cnt: got %0d expected 0", bus.out_cnt); end
      to_drive();
      idle_inputs();
      bus.issue_req = 1'b1;
      bus.issue_rd  = 5'd10;
      past_edge();
      to_drive();
      idle_inputs();
      repeat (2) past_edge();
      vectors++;
      if (bus.wb_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b expected 1", bus.wb_err); end
      vectors++;
      if (bus.pending !== 32'h400) begin miscompares++; $display("FAIL pre_pulse_pending: got %h expected %h", bus.pending, 32'h400); end
      #2;
      resetn = 1'b0;
      #1;
      vectors++;
      if (bus.pending !== 32'h0) begin miscompares++; $display("FAIL pulse_pending: got %h expected 0", bus.pending); end
      vectors++;
      if (bus.out_cnt !== 3'd0) begin miscompares++; $display("FAIL pulse_cnt: got %0d expected 0", bus.out_cnt); end
      vectors++;
      if (bus.wb_err !== 1'b0) begin miscompares++; $display("FAIL pulse_err: got %b expected 0", bus.wb_err); end
      to_drive();
      resetn = 1'b1;
      past_edge();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      resetn      = 1'b0;
      idle_inputs();
      test_reset();
      test_raw_release();
      test_waw();
      test_full();
      test_simul_clear_set();
      test_back_to_back();
      test_flush_err();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mc_scoreboard.md
Name: mc_scoreboard

Overview:
- Producer-side register scoreboard for the 5-stage LoongArch pipeline.
- Records destination registers of multi-cycle writers (divider, load-miss path) when they issue from decode, and clears them when their results return on the writeback bus.
- Generates the decode-stage stall for RAW/WAW hazards against in-flight writers.
- Complements the single-cycle forwarding unit, which only covers E/M/W producers.

Parameters:
- NREG, 32, architectural register count; r0 is never tracked.
- MAX_OUT, 4, maximum outstanding multi-cycle writes (1..NREG-1).
- CNT_W, 3, width of outstanding counter; must satisfy 2^CNT_W > MAX_OUT.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- issue_req  in  1  decode holds a multi-cycle writer requesting issue
- issue_rd  in  5  destination of that writer
- rs1D  in  5  decode source 1 (any instruction)
- rs2D  in  5  decode source 2
- rdD  in  5  decode destination (any writing instruction)
- rdD_we  in  1  decode instruction writes rdD
- wb_valid  in  1  multi-cycle result on writeback bus this cycle
- wb_rd  in  5  writeback destination
- flush  in  1  pipeline flush; multi-cycle units are killed the same cycle
- stall  out  1  hold fetch/decode this cycle
- issue_ack  out  1  issue_req accepted this cycle
- pending  out  NREG  registered pending bitmap; bit 0 always 0
- out_cnt  out  CNT_W  registered outstanding count
- wb_err  out  1  sticky: writeback to a non-pending register

Behaviour:
- Reset (resetn=0, async): pending=0, out_cnt=0, wb_err=0. stall and issue_ack are combinational; with pending=0, they follow the rules below.
- Effective pending for hazard check: effp[r] = pending[r] & ~(wb_valid & wb_rd==r). Same-cycle writeback releases consumers, because the W-stage forward supplies the value.
- raw = (rs1D!=0 & effp[rs1D]) | (rs2D!=0 & effp[rs2D]).
- waw = rdD_we & rdD!=0 & effp[rdD].
- full = (out_cnt == MAX_OUT) & ~(wb_valid & pending[wb_rd]).
- stall = ~flush & (raw | waw | (issue_req & full)).
- issue_ack = issue_req & ~stall & ~flush. issue_rd==0 is acked but sets no bit and does not count.
- Sequential update (rising clk), in priority order:
  - flush: pending<=0, out_cnt<=0; issue and wb ignored; wb_err unchanged.
  - Otherwise, clear then set:
    - wb_valid & pending[wb_rd]: clear bit, decrement count.
    - issue_ack & issue_rd!=0: set bit, increment count.
    - Same register cleared and set in the same cycle: the set wins; net count is unchanged.
  - wb_valid & (wb_rd==0 | ~pending[wb_rd]) & ~flush: wb_err<=1. No bit or count change.
- Invariant: out_cnt == popcount(pending) at every edge. out_cnt never exceeds MAX_OUT and never underflows.
- Latency:
  - Issue to visible pending: 1 cycle. A consumer decoded the cycle after issue stalls.
  - Writeback to release: 0 cycles, via effp.
- A 1-cycle reset pulse mid-operation drops all pending state immediately (async). Outputs are valid from the first edge after release.

Test Plan:
- Reset: hold resetn=0 with wb_valid=1, wb_rd=5 -> pending=0, out_cnt=0, wb_err=0, stall=0; after release, issue_req=1, issue_rd=7 -> issue_ack=1, next cycle pending=0x80, out_cnt=1.
- RAW and release: r7 pending, rs1D=7 -> stall=1 for every cycle until wb_valid=1, wb_rd=7. That cycle stall=0; next cycle pending[7]=0, out_cnt=0.
- WAW: r9 pending, rdD_we=1, rdD=9, rs1D=rs2D=0 -> stall=1. rdD=0 with r0 "pending" attempt (issue_rd=0) -> issue_ack=1, pending unchanged, stall=0.
- Full: issue r1,r2,r3,r4 on consecutive cycles -> out_cnt=4. Issue r5 -> stall=1, issue_ack=0. Same cycle wb_rd=2 -> issue_ack=1; next cycle pending=0x3A, out_cnt=4.
- Simultaneous clear/set: r6 pending, wb_rd=6 and issue_rd=6 same cycle -> issue_ack=1, next cycle pending[6]=1, out_cnt unchanged.
- Flush and error: r3, r4 pending; flush=1 with issue_req=1, issue_rd=8 -> issue_ack=0, stall=0, next cycle pending=0, out_cnt=0. Then wb_valid=1, wb_rd=3 -> wb_err=1 and stays 1 until reset.
